// File: rtl/keypad_poll_ctrl.sv
// Keypad peripheral poll sequencer: polls ready status, reads and acknowledges key
// codes, suppresses repeats/idle codes, and queues new codes in a small FWFT FIFO.
module keypad_poll_ctrl #(
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ZERO_IS_IDLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clr,
  output logic                     statusordata,
  output logic                     ack,
  input  logic [15:0]              keyout,
  output logic [3:0]               key_data,
  output logic                     key_valid,
  input  logic                     key_pop,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(POLL_GAP - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [2:0] S_GAP  = 3'd0;
  localparam logic [2:0] S_STAT = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CAPT = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_nxt;
  logic          sod_nxt;
  logic          ack_nxt;

  logic [3:0]    last_key;
  logic          last_valid;

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          capt_c;
  logic [3:0]    code_c;
  logic          idle_c;
  logic          repeat_c;
  logic          push_c;
  logic          pop_ok_c;
  logic          push_ok_c;
  logic          drop_c;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rd_nxt;
  logic [3:0]    head_nxt;

  // Upper data bits carry no information for this sequencer.
  logic unused_keyout;
  assign unused_keyout = ^keyout[15:4];

  // Next-state logic; only GAP looks at enable, so a started transaction always completes.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GW'(1);
        end else if (enable) begin
          state_nxt = S_STAT;
          gap_nxt   = GAP_RELOAD;
        end
      end
      S_STAT: state_nxt = S_CHK;
      S_CHK:  state_nxt = keyout[0] ? S_DATA : S_GAP;
      S_DATA: state_nxt = S_CAPT;
      S_CAPT: state_nxt = S_ACK;
      S_ACK:  state_nxt = S_GAP;
      default: begin
        state_nxt = S_GAP;
        gap_nxt   = GAP_RELOAD;
      end
    endcase
    sod_nxt = (state_nxt != S_DATA) && (state_nxt != S_CAPT);
    ack_nxt = (state_nxt == S_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_GAP;
      gap_cnt      <= GAP_RELOAD;
      statusordata <= 1'b1;
      ack          <= 1'b0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_nxt;
      statusordata <= sod_nxt;
      ack          <= ack_nxt;
    end
  end

  // Capture filter: drop idle codes and repeats of the last accepted code.
  always_comb begin
    capt_c   = (state == S_CAPT);
    code_c   = keyout[3:0];
    idle_c   = (ZERO_IS_IDLE != 0) && (code_c == 4'h0);
    repeat_c = last_valid && (code_c == last_key);
    push_c   = capt_c && !idle_c && !repeat_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key   <= 4'h0;
      last_valid <= 1'b0;
    end else if (clr) begin
      last_valid <= 1'b0;
    end else if (capt_c) begin
      if (idle_c) begin
        last_valid <= 1'b0;
      end else if (!repeat_c) begin
        last_key   <= code_c;
        last_valid <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    pop_ok_c  = key_pop && (count != '0);
    push_ok_c = push_c && ((count != FULL_COUNT) || pop_ok_c);
    drop_c    = push_c && !push_ok_c;
    count_nxt = count + CW'(push_ok_c) - CW'(pop_ok_c);
    rd_nxt    = rd_ptr + PW'(pop_ok_c);
    head_nxt  = 4'h0;
    if (count_nxt != '0) begin
      if (push_ok_c && (rd_nxt == wr_ptr)) begin
        head_nxt = code_c;
      end else begin
        head_nxt = mem[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push_ok_c) begin
      mem[wr_ptr] <= code_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      key_data  <= 4'h0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      key_data  <= 4'h0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_ptr + PW'(push_ok_c);
      count     <= count_nxt;
      key_data  <= head_nxt;
      key_valid <= (count_nxt != '0);
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_keypad_poll_ctrl.sv
// Self-checking bench for keypad_poll_ctrl: the bench plays the keypad peripheral and
// checks both idle-zero variants against a queue-based model of the filter and FIFO.
module tb_keypad_poll_ctrl;

  localparam int unsigned POLL_GAP = 16;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        key_pop = 1'b0;
  logic [15:0] keyout;
  logic        ready = 1'b0;
  logic [3:0]  code = 4'h0;
  logic [14:0] noise_s = '0;
  logic [11:0] noise_d = '0;

  logic        sodv [2];
  logic        ackv [2];
  logic [3:0]  kd   [2];
  logic        kv   [2];
  logic [2:0]  cnt  [2];
  logic        ovf  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Peripheral read mux: status word carries ready in bit 0, data word the key code.
  always_comb keyout = sodv[0] ? {noise_s, ready} : {noise_d, code};

  keypad_poll_ctrl #(.POLL_GAP(POLL_GAP), .DEPTH(DEPTH), .ZERO_IS_IDLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .statusordata(sodv[0]), .ack(ackv[0]), .keyout(keyout),
    .key_data(kd[0]), .key_valid(kv[0]), .key_pop(key_pop),
    .fifo_count(cnt[0]), .overflow(ovf[0]));

  keypad_poll_ctrl #(.POLL_GAP(POLL_GAP), .DEPTH(DEPTH), .ZERO_IS_IDLE(0)) u_nz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .statusordata(sodv[1]), .ack(ackv[1]), .keyout(keyout),
    .key_data(kd[1]), .key_valid(kv[1]), .key_pop(key_pop),
    .fifo_count(cnt[1]), .overflow(ovf[1]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model state, indexed by instance (0: zero is idle, 1: zero is a key).
  int         m_cnt [2] = '{0, 0};
  bit         m_ovf [2] = '{0, 0};
  bit         m_lv  [2] = '{0, 0};
  logic [3:0] m_lk  [2] = '{4'h0, 4'h0};
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  bit         model_on = 1'b0;
  bit         tmon_on  = 1'b0;
  bit         m_prev_sod = 1'b1;
  bit         capt_m;
  bit         pop_m;

  // Model: check occupancy flags, then apply this cycle's capture/pop/clear.
  always @(negedge clk) begin
    if (model_on) begin
      capt_m = !sodv[0] && !m_prev_sod;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("fifo_count[%0d]", i), cnt[i], m_cnt[i]);
        check($sformatf("key_valid[%0d]", i), kv[i], (m_cnt[i] != 0) ? 1 : 0);
        check($sformatf("overflow[%0d]", i), ovf[i], m_ovf[i]);
        if (m_cnt[i] == 0) check($sformatf("key_data_empty[%0d]", i), kd[i], 0);
        pop_m = key_pop && (m_cnt[i] > 0);
        if (clr) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
          m_lv[i]  = 1'b0;
          if (i == 0) q0.delete(); else q1.delete();
        end else begin
          if (capt_m) begin
            if (i == 0 && code == 4'h0) begin
              m_lv[i] = 1'b0;
            end else if (!(m_lv[i] && code == m_lk[i])) begin
              m_lk[i] = code;
              m_lv[i] = 1'b1;
              if (m_cnt[i] - int'(pop_m) < DEPTH) begin
                if (i == 0) q0.push_back(code); else q1.push_back(code);
                m_cnt[i]++;
              end else begin
                m_ovf[i] = 1'b1;
              end
            end
          end
          if (pop_m) m_cnt[i]--;
        end
      end
      m_prev_sod = sodv[0];
    end
  end

  // Monitor: every accepted pop must present the oldest expected key.
  always @(negedge clk) begin
    if (model_on && key_pop && !clr) begin
      for (int i = 0; i < 2; i++) begin
        if (kv[i]) begin
          if (i == 0) begin
            if (q0.size() == 0) fail_now("pop_with_empty_scoreboard[0]");
            else check("pop_data[0]", kd[0], q0.pop_front());
          end else begin
            if (q1.size() == 0) fail_now("pop_with_empty_scoreboard[1]");
            else check("pop_data[1]", kd[1], q1.pop_front());
          end
        end
      end
    end
  end

  // Bus timing monitor: two data cycles are always followed by a single ack cycle.
  int cyc = 0;
  int falls = 0;
  int fall_cyc [$];
  bit t_p1 = 1'b1;
  bit t_p2 = 1'b1;

  always @(posedge clk) if (rst_n) cyc++;

  always @(negedge clk) begin
    if (tmon_on) begin
      check("sod_both", sodv[1], sodv[0]);
      check("ack_both", ackv[1], ackv[0]);
      if (t_p1 && !sodv[0]) begin
        falls++;
        fall_cyc.push_back(cyc);
      end
      if (!t_p1 && !t_p2) begin
        check("ack_after_capt", ackv[0], 1);
        check("sod_in_ack", sodv[0], 1);
      end else begin
        check("ack_idle", ackv[0], 0);
      end
      t_p2 = t_p1;
      t_p1 = sodv[0];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    noise_s = 15'($urandom);
    noise_d = 12'($urandom);
  end

  task automatic wait_ack(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ackv[0] && n < max_cycles);
    if (!ackv[0]) fail_now("ack_timeout");
  endtask

  task automatic wait_data(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sodv[0] && n < max_cycles);
    if (sodv[0]) fail_now("data_phase_timeout");
  endtask

  task automatic txn(input logic [3:0] c);
    @(posedge clk);
    #1;
    code  = c;
    ready = 1'b1;
    wait_ack(200);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      key_pop = 1'b1;
    end
    @(posedge clk);
    #1;
    key_pop = 1'b0;
  endtask

  int f0;

  initial begin
    enable = 1'b1;
    ready  = 1'b1;
    code   = 4'h5;
    repeat (2) @(negedge clk);
    check("rst_sod", sodv[0], 1);
    check("rst_ack", ackv[0], 0);
    check("rst_valid", kv[0], 0);
    check("rst_count", cnt[0], 0);
    check("rst_key_data", kd[0], 0);
    check("rst_overflow", ovf[0], 0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_on = 1'b1;
    tmon_on  = 1'b1;

    // Repeat suppression and idle handling, plus poll timing with ready held high.
    txn(4'h5);
    txn(4'h5);
    txn(4'h0);
    txn(4'h5);
    @(negedge clk);
    check("filter_count_idle0", cnt[0], 2);
    check("filter_count_nz", cnt[1], 3);
    if (fall_cyc.size() < 3) begin
      fail_now("too_few_transactions");
    end else begin
      check("first_data_cycle", fall_cyc[0], POLL_GAP + 2);
      check("key_period_1", fall_cyc[1] - fall_cyc[0], POLL_GAP + 5);
      check("key_period_2", fall_cyc[2] - fall_cyc[1], POLL_GAP + 5);
    end

    // Not ready: status polling never advances to a data read.
    @(posedge clk);
    #1;
    ready = 1'b0;
    f0 = falls;
    repeat (100) @(posedge clk);
    check("no_data_when_not_ready", falls, f0);
    drain(8);

    // Overflow: fifth distinct key is dropped.
    txn(4'h1);
    txn(4'h2);
    txn(4'h3);
    txn(4'h4);
    txn(4'h6);
    ready = 1'b0;
    @(negedge clk);
    check("full_count", cnt[0], 4);
    check("full_overflow", ovf[0], 1);

    // Clear together with a pop.
    @(posedge clk);
    #1;
    clr = 1'b1;
    key_pop = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    key_pop = 1'b0;
    @(negedge clk);
    check("clr_count", cnt[0], 0);
    check("clr_overflow", ovf[0], 0);

    // Full FIFO with a pop in the capture cycle accepts the new key.
    txn(4'h1);
    txn(4'h2);
    txn(4'h3);
    txn(4'h4);
    code = 4'h7;
    wait_data(200);
    @(posedge clk);
    #1;
    key_pop = 1'b1;
    @(posedge clk);
    #1;
    key_pop = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    check("pop_push_full_count", cnt[0], 4);
    check("pop_push_full_overflow", ovf[0], 0);
    drain(8);

    // Disable during the data phase: transaction completes, then polling parks.
    @(posedge clk);
    #1;
    code  = 4'h9;
    ready = 1'b1;
    wait_data(200);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    f0 = falls;
    repeat (80) @(posedge clk);
    check("parked_after_disable", falls, f0);
    @(negedge clk);
    check("parked_sod", sodv[0], 1);

    // Randomized traffic.
    repeat (1500) begin
      @(posedge clk);
      #1;
      ready   = 1'($urandom_range(0, 1));
      code    = 4'($urandom_range(0, 3));
      key_pop = ($urandom_range(0, 9) < 3);
      clr     = ($urandom_range(0, 99) == 0);
      enable  = ($urandom_range(0, 15) != 0);
    end

    // Asynchronous reset in the ack cycle drops ack immediately.
    clr = 1'b0;
    key_pop = 1'b0;
    enable = 1'b1;
    ready = 1'b1;
    wait_ack(200);
    model_on = 1'b0;
    tmon_on  = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", ackv[0], 0);
    check("async_rst_sod", sodv[0], 1);
    check("async_rst_valid", kv[0], 0);
    check("async_rst_count", cnt[0], 0);
    check("async_rst_overflow", ovf[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_poll_ctrl.md
Name: keypad_poll_ctrl

Overview:
- Bus-side sequencer for the 4x4 keypad peripheral's status/data/ack register interface.
- Periodically polls the peripheral's ready status. When ready is set, it reads the 4-bit key code, acknowledges it, filters out repeats and idle codes, and pushes new key codes into a small FIFO.
- Consumers (the display or command logic) pop key codes through a valid/pop handshake, so none of them drive the peripheral directly.

Parameters:
- POLL_GAP, 16: idle cycles in GAP between poll transactions (minimum 1).
- DEPTH, 4: FIFO entries (power of two, minimum 2).
- ZERO_IS_IDLE, 1: when 1, a captured code 4'h0 means "no key": it is not pushed and it re-arms repeat suppression.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable
- clr  in  1  synchronous flush of FIFO, overflow and last-key state
- statusordata  out  1  peripheral select: 1 = status, 0 = data
- ack  out  1  peripheral acknowledge, one-cycle pulse
- keyout  in  16  peripheral read data (combinational from statusordata)
- key_data  out  4  FIFO head key code
- key_valid  out  1  FIFO not empty
- key_pop  in  1  consumer pop; ignored when key_valid=0
- fifo_count  out  3  occupancy, 0..DEPTH (width $clog2(DEPTH)+1)
- overflow  out  1  sticky: a key was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=GAP, gap counter=POLL_GAP-1
  - statusordata=1, ack=0
  - FIFO empty: key_valid=0, fifo_count=0, key_data=0
  - overflow=0, last_valid=0
- statusordata and ack are registered and decoded from the state register only; no combinational path from keyout to them.
- FSM states:
  - GAP: statusordata=1, ack=0. Counter decrements each cycle. At 0 with enable=1 go to STAT and reload the counter. At 0 with enable=0 stay in GAP with the counter held at 0.
  - STAT: statusordata=1, settling cycle. Go to CHK.
  - CHK: statusordata=1. Sample keyout[0]. If 1 go to DATA, else go to GAP.
  - DATA: statusordata=0, settling cycle. Go to CAPT.
  - CAPT: statusordata=0. Latch keyout[3:0] into cap and run the filter. Go to ACK.
  - ACK: ack=1, statusordata=1, exactly one cycle. Go to GAP.
- Minimum poll period = POLL_GAP+2 cycles (no key). A transaction that finds a key takes POLL_GAP+5 cycles.
- Deasserting enable mid-transaction (STAT..ACK) does not abort: the sequence completes through ACK, then the FSM parks in GAP. ack is never left asserted.
- Filter, applied in the CAPT cycle:
  - ZERO_IS_IDLE=1 and cap==0: last_valid<=0; no push.
  - last_valid=1 and cap==last_key: no push.
  - Otherwise: push cap; last_key<=cap; last_valid<=1.
- FIFO: circular buffer, first-word fall-through.
  - key_data = entry at the read pointer; key_data=0 when empty.
  - key_valid and fifo_count update the cycle after a push or pop.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Not full: both happen; count unchanged.
  - Full: the pop frees a slot, the push is accepted, overflow unchanged.
  - Empty: the push happens; the pop is ignored (key_valid=0).
- Push while full without pop: the new key is dropped and overflow<=1. last_key is still updated, so the same held key does not retrigger.
- clr=1: empties the FIFO, sets overflow=0 and last_valid=0. clr has priority over push and pop in the same cycle. The FSM is unaffected.
- keyout[15:1] is ignored in CHK; keyout[15:4] is ignored in CAPT.

Test Plan:
- Reset then enable=1, model status ready=0 -> statusordata stays 1, ack never 1, CHK visited every POLL_GAP+2 cycles, key_valid=0.
- Model ready=1 with data 4'h5 -> statusordata pattern 1,1,0,0 then ack=1 for one cycle. key_valid=1 and key_data=4'h5 in the cycle after the ACK cycle. fifo_count=1.
- Same code 4'h5 on consecutive polls, then 4'h0, then 4'h5 -> only two pushes of 4'h5. With ZERO_IS_IDLE=0 the same sequence gives pushes 5, 0, 5.
- Push codes 1,2,3,4,6 without pops (DEPTH=4) -> fifo_count=4, overflow=1, pops return 1,2,3,4, then key_valid=0.
- With the FIFO full, pop in the same cycle as the CAPT push of 4'h7 -> count stays 4, overflow stays 0, last entry popped = 4'h7.
- enable dropped in the DATA cycle -> CAPT and ACK still occur, then GAP is held. clr during a pop -> count=0, overflow=0. rst_n low during ACK -> ack=0 immediately (asynchronous).
